// File: rtl/bloom_filter_pkg.sv
// Shared definitions for bloom_filter and its standalone configuration master.
package bloom_filter_pkg;

    // Avalon-MM slave port geometry
    localparam int AMM_CSR_ADDR_W = 4;
    localparam int AMM_CSR_DATA_W = 32;
    localparam int AMM_LUT_ADDR_W = 8;
    localparam int AMM_LUT_DATA_W = 32;

    // CSR word offsets
    localparam logic [AMM_CSR_ADDR_W-1:0] EN             = 4'h0;
    localparam logic [AMM_CSR_ADDR_W-1:0] HASH_LUT_CLEAN = 4'h2;

    // Configuration master
    localparam int BF_CFG_STATUS_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAN_WR,
        POLL_GAP,
        POLL_RD,
        POLL_CHK,
        LUT_WR,
        EN_WR,
        FINISH
    } bf_cfg_state_t;

endpackage

// File: rtl/bf_cfg_poll_timer.sv
// Timing helper for the clean-poll loop: idle gap between status reads,
// read-latency delay line that marks when readdata is valid, and a
// saturating poll counter that flags the timeout limit.
module bf_cfg_poll_timer #(
    parameter int GAP_CYCLES   = 50,
    parameter int MAX_POLLS    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,        // new sequence accepted
    input  logic i_gap_run,      // FSM is waiting between polls
    input  logic i_read,         // CSR read strobe as driven on the bus
    output logic o_gap_done,     // last gap cycle
    output logic o_sample_valid, // readdata for the last read is valid now
    output logic o_poll_limit    // MAX_POLLS reads have been issued
);

    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int POLL_W = $clog2(MAX_POLLS + 1);

    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(MAX_POLLS);

    logic [GAP_W-1:0]        r_gap_cnt;
    logic [READ_LATENCY-1:0] r_rd_dly;
    logic [POLL_W-1:0]       r_poll_cnt;

    assign o_gap_done     = i_gap_run && (r_gap_cnt == GAP_LAST);
    assign o_sample_valid = r_rd_dly[READ_LATENCY-1];
    assign o_poll_limit   = (r_poll_cnt >= POLL_MAX);

    // Gap counter: runs only while the FSM sits in the gap state, parks at 0 otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap_cnt <= '0;
        // NOTE: state is updated with <= so every register sees pre-edge values of the others.
        end else if (!i_gap_run || o_gap_done) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end
    end

    // Delay line: the read strobe emerges READ_LATENCY cycles later as the sample point.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_dly <= '0;
        end else begin
            r_rd_dly <= READ_LATENCY'({r_rd_dly, i_read});
        end
    end

    // Poll counter: counts issued reads per sequence, saturates at the limit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_poll_cnt <= '0;
        end else if (i_clear) begin
            r_poll_cnt <= '0;
        end else if (i_read && !o_poll_limit) begin
            r_poll_cnt <= r_poll_cnt + POLL_W'(1);
        end
    end

endmodule

// File: rtl/bf_cfg_master.sv
// Avalon-MM initiator that configures bloom_filter on a start pulse:
// clean the hash LUT and poll for completion, stream LUT words from a
// valid/ready source into the LUT port, then set EN.
module bf_cfg_master
    import bloom_filter_pkg::AMM_CSR_ADDR_W, bloom_filter_pkg::AMM_CSR_DATA_W,
           bloom_filter_pkg::AMM_LUT_ADDR_W, bloom_filter_pkg::AMM_LUT_DATA_W,
           bloom_filter_pkg::EN, bloom_filter_pkg::HASH_LUT_CLEAN,
           bloom_filter_pkg::BF_CFG_STATUS_W, bloom_filter_pkg::bf_cfg_state_t,
           bloom_filter_pkg::IDLE, bloom_filter_pkg::CLEAN_WR, bloom_filter_pkg::POLL_RD,
           bloom_filter_pkg::POLL_CHK, bloom_filter_pkg::LUT_WR, bloom_filter_pkg::EN_WR,
           bloom_filter_pkg::FINISH;
#(
    parameter int POLL_GAP     = 50,
    parameter int MAX_POLLS    = 1024,
    parameter int READ_LATENCY = 1,
    parameter bit SKIP_CLEAN   = 1'b0,
    parameter int LUT_ADDR_W   = AMM_LUT_ADDR_W
) (
    input  logic                       main_clk_i,
    input  logic                       main_arst_n_i,
    input  logic                       start_i,
    input  logic                       lut_stream_valid_i,
    output logic                       lut_stream_ready_o,
    input  logic [AMM_LUT_DATA_W-1:0]  lut_stream_data_i,
    input  logic                       lut_stream_last_i,
    output logic [AMM_CSR_ADDR_W-1:0]  amm_csr_address_o,
    output logic                       amm_csr_read_o,
    input  logic [AMM_CSR_DATA_W-1:0]  amm_csr_readdata_i,
    output logic                       amm_csr_write_o,
    output logic [AMM_CSR_DATA_W-1:0]  amm_csr_writedata_o,
    output logic [LUT_ADDR_W-1:0]      amm_lut_address_o,
    output logic                       amm_lut_write_o,
    output logic [AMM_LUT_DATA_W-1:0]  amm_lut_writedata_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [BF_CFG_STATUS_W-1:0] status_o
);

    localparam logic [LUT_ADDR_W-1:0] LUT_ADDR_LAST = '1;

    bf_cfg_state_t r_state;

    logic                       r_csr_read;
    logic                       r_csr_write;
    logic [AMM_CSR_ADDR_W-1:0]  r_csr_addr;
    logic [AMM_CSR_DATA_W-1:0]  r_csr_wdata;
    logic                       r_lut_write;
    logic [LUT_ADDR_W-1:0]      r_lut_addr;
    logic [AMM_LUT_DATA_W-1:0]  r_lut_wdata;
    logic [LUT_ADDR_W-1:0]      r_addr_cnt;
    logic                       r_ready;
    logic                       r_done;
    logic [BF_CFG_STATUS_W-1:0] r_status;

    logic w_start_ok;
    logic w_handshake;
    logic w_addr_full;
    logic w_gap_run;
    logic w_gap_done;
    logic w_sample_valid;
    logic w_poll_limit;

    assign w_start_ok  = (r_state == IDLE) && start_i;
    // r_ready is only ever high in LUT_WR, so stream valid is ignored elsewhere
    assign w_handshake = r_ready && lut_stream_valid_i;
    assign w_addr_full = (r_addr_cnt == LUT_ADDR_LAST);
    // The POLL_GAP state name is shadowed by the parameter, hence the qualified reference
    assign w_gap_run   = (r_state == bloom_filter_pkg::POLL_GAP);

    bf_cfg_poll_timer #(
        .GAP_CYCLES   (POLL_GAP),
        .MAX_POLLS    (MAX_POLLS),
        .READ_LATENCY (READ_LATENCY)
    ) u_poll_timer (
        .i_clk          (main_clk_i),
        .i_rst_n        (main_arst_n_i),
        .i_clear        (w_start_ok),
        .i_gap_run      (w_gap_run),
        .i_read         (r_csr_read),
        .o_gap_done     (w_gap_done),
        .o_sample_valid (w_sample_valid),
        .o_poll_limit   (w_poll_limit)
    );

    // Sequencer FSM with registered bus strobes, stream ready, done pulse and status.
    always_ff @(posedge main_clk_i or negedge main_arst_n_i) begin
        if (!main_arst_n_i) begin
            r_state     <= IDLE;
            r_csr_read  <= 1'b0;
            r_csr_write <= 1'b0;
            r_csr_addr  <= '0;
            r_csr_wdata <= '0;
            r_lut_write <= 1'b0;
            r_lut_addr  <= '0;
            r_lut_wdata <= '0;
            r_addr_cnt  <= '0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_status    <= '0;
        end else begin
            // NOTE: defaults at the top make every strobe a one-cycle pulse and zero idle address/data.
            r_csr_read  <= 1'b0;
            r_csr_write <= 1'b0;
            r_csr_addr  <= '0;
            r_csr_wdata <= '0;
            r_lut_write <= 1'b0;
            r_lut_addr  <= '0;
            r_lut_wdata <= '0;
            r_done      <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_status   <= '0;
                        r_addr_cnt <= '0;
                        if (SKIP_CLEAN) begin
                            r_state <= LUT_WR;
                            r_ready <= 1'b1;
                        end else begin
                            r_state     <= CLEAN_WR;
                            r_csr_write <= 1'b1;
                            r_csr_addr  <= HASH_LUT_CLEAN;
                            r_csr_wdata <= AMM_CSR_DATA_W'(1);
                        end
                    end
                end

                CLEAN_WR: r_state <= bloom_filter_pkg::POLL_GAP;

                bloom_filter_pkg::POLL_GAP: begin
                    if (w_gap_done) begin
                        r_state    <= POLL_RD;
                        r_csr_read <= 1'b1;
                        r_csr_addr <= HASH_LUT_CLEAN;
                    end
                end

                POLL_RD: r_state <= POLL_CHK;

                POLL_CHK: begin
                    if (w_sample_valid) begin
                        if (amm_csr_readdata_i == '0) begin
                            r_state <= LUT_WR;
                            r_ready <= 1'b1;
                        end else if (!w_poll_limit) begin
                            r_state <= bloom_filter_pkg::POLL_GAP;
                        end else begin
                            r_status[0] <= 1'b1;
                            r_state     <= FINISH;
                            r_done      <= 1'b1;
                        end
                    end
                end

                LUT_WR: begin
                    if (w_handshake) begin
                        r_lut_write <= 1'b1;
                        r_lut_addr  <= r_addr_cnt;
                        r_lut_wdata <= lut_stream_data_i;
                        if (lut_stream_last_i || w_addr_full) begin
                            // Counter holds at the top address instead of wrapping
                            r_ready     <= 1'b0;
                            r_state     <= EN_WR;
                            r_csr_write <= 1'b1;
                            r_csr_addr  <= EN;
                            r_csr_wdata <= AMM_CSR_DATA_W'(1);
                            if (!lut_stream_last_i) begin
                                r_status[1] <= 1'b1;
                            end
                        end else begin
                            r_addr_cnt <= r_addr_cnt + LUT_ADDR_W'(1);
                        end
                    end
                end

                EN_WR: begin
                    r_state <= FINISH;
                    r_done  <= 1'b1;
                end

                FINISH: r_state <= IDLE;

                default: r_state <= IDLE;
            endcase
        end
    end

    assign amm_csr_address_o   = r_csr_addr;
    assign amm_csr_read_o      = r_csr_read;
    assign amm_csr_write_o     = r_csr_write;
    assign amm_csr_writedata_o = r_csr_wdata;
    assign amm_lut_address_o   = r_lut_addr;
    assign amm_lut_write_o     = r_lut_write;
    assign amm_lut_writedata_o = r_lut_wdata;
    assign lut_stream_ready_o  = r_ready;
    assign busy_o              = (r_state != IDLE);
    assign done_o              = r_done;
    assign status_o            = r_status;

endmodule

// File: tb/tb_bf_cfg_master.sv
// Bench for bf_cfg_master: a slave/stream model records bus traffic and
// the expected sequence is derived from the configuration rules.
module tb_bf_cfg_master;
    import bloom_filter_pkg::*;

    localparam int TB_GAP    = 5;
    localparam int TB_MAX    = 4;
    localparam int TB_LAT    = 1;
    localparam int TB_LW     = 3;
    localparam int LUT_DEPTH = 1 << TB_LW;
    localparam int BUDGET    = 2000;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start;
    logic                       s_valid;
    logic                       s_ready;
    logic [AMM_LUT_DATA_W-1:0]  s_data;
    logic                       s_last;
    logic [AMM_CSR_ADDR_W-1:0]  csr_addr;
    logic                       csr_read;
    logic [AMM_CSR_DATA_W-1:0]  csr_rdata;
    logic                       csr_write;
    logic [AMM_CSR_DATA_W-1:0]  csr_wdata;
    logic [TB_LW-1:0]           lut_addr;
    logic                       lut_write;
    logic [AMM_LUT_DATA_W-1:0]  lut_wdata;
    logic                       busy;
    logic                       done;
    logic [BF_CFG_STATUS_W-1:0] status;

    always #5 clk = ~clk;

    bf_cfg_master #(
        .POLL_GAP     (TB_GAP),
        .MAX_POLLS    (TB_MAX),
        .READ_LATENCY (TB_LAT),
        .SKIP_CLEAN   (1'b0),
        .LUT_ADDR_W   (TB_LW)
    ) dut (
        .main_clk_i          (clk),
        .main_arst_n_i       (rst_n),
        .start_i             (start),
        .lut_stream_valid_i  (s_valid),
        .lut_stream_ready_o  (s_ready),
        .lut_stream_data_i   (s_data),
        .lut_stream_last_i   (s_last),
        .amm_csr_address_o   (csr_addr),
        .amm_csr_read_o      (csr_read),
        .amm_csr_readdata_i  (csr_rdata),
        .amm_csr_write_o     (csr_write),
        .amm_csr_writedata_o (csr_wdata),
        .amm_lut_address_o   (lut_addr),
        .amm_lut_write_o     (lut_write),
        .amm_lut_writedata_o (lut_wdata),
        .busy_o              (busy),
        .done_o              (done),
        .status_o            (status)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus configuration ----------------
    logic [AMM_LUT_DATA_W-1:0] src [16];
    int                        src_n;
    int                        last_idx;
    bit                        gaps;
    bit                        stream_en;
    logic [AMM_CSR_DATA_W-1:0] resp_arr [8];
    int                        resp_n;
    logic [AMM_CSR_DATA_W-1:0] poll_default;
    logic [AMM_CSR_DATA_W-1:0] rd_idle;

    function automatic logic [AMM_CSR_DATA_W-1:0] resp_for(input int k);
        if (k < resp_n) return resp_arr[k];
        return poll_default;
    endfunction

    // ---------------- bus/stream log ----------------
    typedef struct { int cyc; logic [AMM_CSR_ADDR_W-1:0] addr; logic [AMM_CSR_DATA_W-1:0] data; } csr_ev_t;
    typedef struct { int cyc; logic [TB_LW-1:0] addr; logic [AMM_LUT_DATA_W-1:0] data; } lut_ev_t;
    typedef struct { int cyc; logic [AMM_LUT_DATA_W-1:0] data; } hs_ev_t;
    typedef struct { int due; logic [AMM_CSR_DATA_W-1:0] val; } rd_ev_t;

    csr_ev_t csr_wr_q [$];
    csr_ev_t csr_rd_q [$];
    lut_ev_t lut_q [$];
    hs_ev_t  hs_q [$];
    rd_ev_t  rd_pend [$];
    int      cyc = 0;
    int      done_cnt;
    int      done_cyc;
    logic [1:0] done_status;
    int      rule_viol;
    int      n_reads_seen;
    logic    prev_rd = 1'b0;
    logic    prev_wr = 1'b0;
    int      drv_idx;

    always @(posedge clk) cyc++;

    // CSR slave model, bus-rule watcher and traffic recorder (mid-cycle, outputs stable)
    always @(negedge clk) begin
        if (rd_pend.size() > 0 && rd_pend[0].due == cyc) begin
            csr_rdata = rd_pend[0].val;
            void'(rd_pend.pop_front());
        end else begin
            csr_rdata = rd_idle;
        end
        if (csr_read && csr_write) rule_viol++;
        if (!csr_read && !csr_write && csr_addr != '0) rule_viol++;
        if (!csr_write && csr_wdata != '0) rule_viol++;
        if (!lut_write && (lut_addr != '0 || lut_wdata != '0)) rule_viol++;
        if ((csr_read && prev_rd) || (csr_write && prev_wr)) rule_viol++;
        if ((s_ready || done) && !busy) rule_viol++;
        prev_rd = csr_read;
        prev_wr = csr_write;
        if (csr_write) csr_wr_q.push_back('{cyc, csr_addr, csr_wdata});
        if (csr_read) begin
            csr_rd_q.push_back('{cyc, csr_addr, '0});
            rd_pend.push_back('{cyc + TB_LAT, resp_for(n_reads_seen)});
            n_reads_seen++;
        end
        if (lut_write) lut_q.push_back('{cyc, lut_addr, lut_wdata});
        if (s_valid && s_ready) hs_q.push_back('{cyc, s_data});
        if (done) begin
            done_cnt++;
            done_cyc    = cyc;
            done_status = status;
        end
    end

    // Stream source: presents word[number of accepted words], optionally with random bubbles
    always @(posedge clk) begin
        #1;
        drv_idx = hs_q.size();
        if (stream_en && drv_idx < src_n) begin
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = src[drv_idx];
            s_last  = (drv_idx == last_idx);
        end else begin
            s_valid = 1'b0;
            s_data  = '0;
            s_last  = 1'b0;
        end
    end

    task automatic clear_logs();
        csr_wr_q.delete();
        csr_rd_q.delete();
        lut_q.delete();
        hs_q.delete();
        rd_pend.delete();
        done_cnt     = 0;
        rule_viol    = 0;
        n_reads_seen = 0;
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk); #1;
        start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs one full sequence and compares the recorded traffic with the expected one
    task automatic run_seq(input string name, input bit inject_start);
        int s;
        int budget;
        bit injected;
        int n_exp_reads;
        int lut_exp;
        bit timeout;
        bit overflow;
        int m;
        injected = 1'b0;
        clear_logs();
        stream_en = 1'b1;
        pulse_start(s);
        budget = 0;
        while (done_cnt == 0 && budget < BUDGET) begin
            @(posedge clk); #1;
            budget++;
            start = 1'b0;
            if (inject_start && !injected && hs_q.size() >= 1 && s_ready) begin
                start    = 1'b1;
                injected = 1'b1;
            end
        end
        start = 1'b0;
        check({name, ":done_seen"}, (done_cnt != 0), 1);
        repeat (4) @(posedge clk);
        #1;
        stream_en = 1'b0;

        // expected sequence from the configuration rules
        n_exp_reads = 0;
        timeout = 1'b1;
        for (int k = 0; k < TB_MAX; k++) begin
            n_exp_reads++;
            if (resp_for(k) == '0) begin
                timeout = 1'b0;
                break;
            end
        end
        lut_exp  = 0;
        overflow = 1'b0;
        if (!timeout) begin
            for (int i = 0; i < src_n; i++) begin
                lut_exp++;
                if (i == last_idx) break;
                if (lut_exp == LUT_DEPTH) begin
                    overflow = 1'b1;
                    break;
                end
            end
        end

        check({name, ":n_reads"}, csr_rd_q.size(), n_exp_reads);
        m = (csr_rd_q.size() < n_exp_reads) ? csr_rd_q.size() : n_exp_reads;
        for (int k = 0; k < m; k++) begin
            check($sformatf("%s:rd%0d_addr", name, k), csr_rd_q[k].addr, HASH_LUT_CLEAN);
            check($sformatf("%s:rd%0d_cyc", name, k), csr_rd_q[k].cyc,
                  s + TB_GAP + 2 + k * (TB_GAP + 1 + TB_LAT));
        end

        check({name, ":n_csr_writes"}, csr_wr_q.size(), timeout ? 1 : 2);
        if (csr_wr_q.size() >= 1) begin
            check({name, ":clean_addr"}, csr_wr_q[0].addr, HASH_LUT_CLEAN);
            check({name, ":clean_data"}, csr_wr_q[0].data, 1);
            check({name, ":clean_cyc"}, csr_wr_q[0].cyc, s + 1);
        end
        if (!timeout && csr_wr_q.size() >= 2) begin
            check({name, ":en_addr"}, csr_wr_q[1].addr, EN);
            check({name, ":en_data"}, csr_wr_q[1].data, 1);
            check({name, ":done_after_en"}, done_cyc, csr_wr_q[1].cyc + 1);
        end
        if (timeout && csr_rd_q.size() > 0) begin
            check({name, ":done_after_poll"}, done_cyc, csr_rd_q[csr_rd_q.size()-1].cyc + TB_LAT + 1);
        end

        check({name, ":n_handshakes"}, hs_q.size(), lut_exp);
        check({name, ":n_lut_writes"}, lut_q.size(), lut_exp);
        m = (lut_q.size() < lut_exp) ? lut_q.size() : lut_exp;
        if (hs_q.size() < m) m = hs_q.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s:lut%0d_addr", name, i), lut_q[i].addr, i);
            check($sformatf("%s:lut%0d_data", name, i), lut_q[i].data, src[i]);
            check($sformatf("%s:lut%0d_cyc", name, i), lut_q[i].cyc, hs_q[i].cyc + 1);
        end

        check({name, ":done_count"}, done_cnt, 1);
        check({name, ":done_status"}, done_status, {overflow, timeout});
        check({name, ":status_held"}, status, {overflow, timeout});
        check({name, ":idle_after"}, {busy, s_ready}, 2'b00);
        check({name, ":bus_rules"}, rule_viol, 0);
    endtask

    task automatic set_words(input int n, input int last_at);
        src_n    = n;
        last_idx = last_at;
        for (int i = 0; i < 16; i++) src[i] = $urandom;
    endtask

    initial begin
        int s;
        int budget;
        int nones;
        rst_n        = 1'b0;
        start        = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        s_last       = 1'b0;
        csr_rdata    = '0;
        stream_en    = 1'b0;
        gaps         = 1'b0;
        resp_n       = 0;
        poll_default = 1;
        rd_idle      = '0;
        src_n        = 0;
        last_idx     = -1;
        clear_logs();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset:csr_side", {csr_addr, csr_read, csr_write, csr_wdata}, '0);
        check("reset:lut_side", {lut_addr, lut_write, lut_wdata, s_ready, busy, done, status}, '0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // clean polls 1,1,0 then four words, last on the fourth
        resp_arr[0] = 1; resp_arr[1] = 1; resp_arr[2] = 0; resp_n = 3;
        rd_idle = 32'hDEAD_BEEF;
        gaps = 1'b0;
        set_words(4, 3);
        run_seq("clean_load", 1'b0);

        // clean never completes
        resp_n = 0; poll_default = 32'h1; rd_idle = '0;
        set_words(4, 3);
        run_seq("timeout", 1'b0);

        // ten words without last overflow an 8-entry LUT
        resp_arr[0] = 0; resp_n = 1; rd_idle = 32'h0000_0100;
        set_words(10, -1);
        run_seq("overflow", 1'b0);

        // random polls, lengths and stream bubbles
        gaps = 1'b1;
        for (int it = 0; it < 3; it++) begin
            nones = $urandom_range(0, 2);
            for (int k = 0; k < nones; k++) resp_arr[k] = $urandom | 32'h1;
            resp_arr[nones] = 0;
            resp_n = nones + 1;
            rd_idle = $urandom | 32'h8000_0000;
            set_words($urandom_range(1, LUT_DEPTH), -1);
            last_idx = src_n - 1;
            run_seq($sformatf("stall%0d", it), 1'b0);
        end
        gaps = 1'b0;

        // async reset in the middle of the LUT load
        resp_arr[0] = 0; resp_n = 1; rd_idle = 32'h3;
        set_words(6, 5);
        clear_logs();
        stream_en = 1'b1;
        pulse_start(s);
        budget = 0;
        while (hs_q.size() < 3 && budget < BUDGET) begin
            @(posedge clk); #1;
            budget++;
        end
        check("arst:reached_lut_wr", (hs_q.size() >= 3), 1);
        check("arst:write_in_flight", lut_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst:csr_side", {csr_addr, csr_read, csr_write, csr_wdata}, '0);
        check("arst:lut_side", {lut_addr, lut_write, lut_wdata, s_ready, busy, done, status}, '0);
        stream_en = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        set_words(5, 4);
        run_seq("after_arst", 1'b0);

        // start pulse while loading is ignored
        resp_arr[0] = 1; resp_arr[1] = 0; resp_n = 2; rd_idle = '0;
        set_words(5, 4);
        run_seq("start_busy", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
